data_sram_ctrl: RTL

- Data-memory controller directly downstream of cpu_core's memory stage.
- Consumes mem_addr, mem_wdata and mem_ctrl_signal; drives an asynchronous 32-bit SRAM (ThinPad-style: ce_n/oe_n/we_n/be_n, 20-bit word address); returns mem_rdata and mem_stall.
- Converts single-cycle CPU requests into multi-cycle SRAM read/write sequences, with byte-lane steering and load extension.

---
 rtl/data_sram_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl
// Data-memory controller sitting behind the CPU memory stage. Turns a
// single-cycle load/store request into a multi-cycle access on an
// asynchronous 32-bit SRAM, with store byte-lane steering and load extension.
//
// Ports:
//   clk_50M, reset_btn        clock, synchronous active-high reset
//   mem_addr, mem_wdata       byte address and right-aligned store data
//   mem_ctrl_signal[4:0]      [4] valid, [3] store, [2:1] size, [0] sign-extend
//   mem_rdata                 extended load result (held until next load)
//   mem_stall                 pipeline hold, combinational
//   addr_err                  one-cycle pulse on misaligned/illegal request
//   sram_addr, sram_dq_o/i,   SRAM word address and data bus halves
//   sram_dq_oe                tri-state enable for sram_dq_o
//   sram_ce_n/oe_n/we_n/be_n  active-low SRAM strobes and byte enables
module data_sram_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk_50M,
  input  logic               reset_btn,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [4:0]         mem_ctrl_signal,
  output logic [31:0]        mem_rdata,
  output logic               mem_stall,
  output logic               addr_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_o,
  input  logic [31:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [1:0]  addr_lo_reg;
  logic [1:0]  size_reg;
  logic        sign_reg;
  logic        store_reg;

  logic        req_valid;
  logic        req_store;
  logic [1:0]  req_size;
  logic        misaligned;
  logic [31:0] wdata_steer;
  logic [3:0]  be_steer;
  logic [31:0] load_ext;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Address bits above the SRAM window are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:SRAM_AW+2];

  assign req_valid = mem_ctrl_signal[4];
  assign req_store = mem_ctrl_signal[3];
  assign req_size  = mem_ctrl_signal[2:1];

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = mem_addr[0];
      2'b10:   misaligned = (mem_addr[1:0] != 2'b00);
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Stores replicate the data across lanes and let be_n pick the lane;
  // loads always read the full word and extract afterwards.
  always_comb begin
    wdata_steer = mem_wdata;
    be_steer    = 4'b0000;
    if (req_store) begin
      case (req_size)
        2'b00: begin
          wdata_steer = {4{mem_wdata[7:0]}};
          be_steer    = ~(4'b0001 << mem_addr[1:0]);
        end
        2'b01: begin
          wdata_steer = {2{mem_wdata[15:0]}};
          be_steer    = mem_addr[1] ? 4'b0011 : 4'b1100;
        end
        default: begin
          wdata_steer = mem_wdata;
          be_steer    = 4'b0000;
        end
      endcase
    end
  end

  // Lane extraction uses the latched request, not the live inputs.
  always_comb begin
    load_byte = 8'(sram_dq_i >> {addr_lo_reg, 3'b000});
    load_half = addr_lo_reg[1] ? sram_dq_i[31:16] : sram_dq_i[15:0];
    case (size_reg)
      2'b00:   load_ext = sign_reg ? {{24{load_byte[7]}}, load_byte} : {24'h0, load_byte};
      2'b01:   load_ext = sign_reg ? {{16{load_half[15]}}, load_half} : {16'h0, load_half};
      default: load_ext = sram_dq_i;
    endcase
  end

  assign mem_stall = req_valid && (state_reg != DONE) && !reset_btn;

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      addr_lo_reg <= 2'b00;
      size_reg    <= 2'b00;
      sign_reg    <= 1'b0;
      store_reg   <= 1'b0;
      mem_rdata   <= 32'h0;
      addr_err    <= 1'b0;
      sram_addr   <= '0;
      sram_dq_o   <= 32'h0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_be_n   <= 4'hF;
    end else begin
      case (state_reg)
        IDLE: begin
          addr_err <= 1'b0;
          if (req_valid) begin
            if (misaligned) begin
              // No SRAM cycle at all; just report and release the pipeline.
              state_reg <= DONE;
              addr_err  <= 1'b1;
              mem_rdata <= 32'h0;
            end else begin
              state_reg   <= ACCESS;
              cnt_reg     <= CNT_INIT;
              addr_lo_reg <= mem_addr[1:0];
              size_reg    <= req_size;
              sign_reg    <= mem_ctrl_signal[0];
              store_reg   <= req_store;
              sram_addr   <= mem_addr[SRAM_AW+1:2];
              sram_dq_o   <= wdata_steer;
              sram_be_n   <= be_steer;
              sram_ce_n   <= 1'b0;
              sram_oe_n   <= req_store;
              sram_we_n   <= !req_store;
              sram_dq_oe  <= req_store;
            end
          end
        end
        ACCESS: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= DONE;
            if (store_reg) begin
              // End the write pulse but keep data driven one more cycle
              // so the SRAM sees hold time after we_n rises.
              sram_we_n <= 1'b1;
            end else begin
              mem_rdata <= load_ext;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        DONE: begin
          state_reg  <= IDLE;
          addr_err   <= 1'b0;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          sram_be_n  <= 4'hF;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
